// File: rtl/exc_sequencer_if.sv
// Request/strobe bundle between decode, CP0 and the exception sequencer.
// The sequencer takes the slave view; the driving environment takes the master view.
interface exc_sequencer_if #(
  parameter int N_IRQ = 6
) ();
  logic             sync_exc_valid;
  logic [4:0]       sync_exc_code;
  logic             eret_req;
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] irq_mask;
  logic [N_IRQ-1:0] irq_clr;
  logic             ie;
  logic             cp0_ans;
  logic             cp0_exception;
  logic             cp0_eret;
  logic [4:0]       cp0_cause;
  logic             stall;
  logic             flush;
  logic [N_IRQ-1:0] irq_pending;

  modport master (
    output sync_exc_valid, sync_exc_code, eret_req, irq, irq_mask, irq_clr, ie, cp0_ans,
    input  cp0_exception, cp0_eret, cp0_cause, stall, flush, irq_pending
  );

  modport slave (
    input  sync_exc_valid, sync_exc_code, eret_req, irq, irq_mask, irq_clr, ie, cp0_ans,
    output cp0_exception, cp0_eret, cp0_cause, stall, flush, irq_pending
  );
endinterface

// File: rtl/exc_sequencer.sv
// Arbitrates sync exceptions, eret and latched interrupts into single CP0 requests,
// holding the pipeline while a request is in flight and flushing after entry/return.
module exc_sequencer #(
  parameter int N_IRQ        = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  exc_sequencer_if.slave  bus
);

  localparam logic [3:0] LP_FLUSH = 4'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RET,
    ST_FLUSH
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [4:0]       r_cause;
  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] r_pending;
  logic             r_exc;
  logic             r_eret;
  logic             r_stall;
  logic             r_flush;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_pending_next;
  logic             w_irq_take;

  // Set wins over the software clear when both hit the same bit in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_pend
      assign w_rise[gi]         = bus.irq[gi] & ~r_irq_q[gi];
      assign w_pending_next[gi] = w_rise[gi] | (r_pending[gi] & ~bus.irq_clr[gi]);
    end
  endgenerate

  assign w_irq_take = bus.ie & (|(r_pending & bus.irq_mask));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_q   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_q   <= bus.irq;
      r_pending <= w_pending_next;
    end
  end

  // Outputs are registered alongside the state so they never depend on inputs combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_cause <= 5'd0;
      r_exc   <= 1'b0;
      r_eret  <= 1'b0;
      r_stall <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_exc  <= 1'b0;
      r_eret <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.sync_exc_valid) begin
            r_cause <= bus.sync_exc_code;
            r_exc   <= 1'b1;
            r_stall <= 1'b1;
            r_state <= ST_REQ;
          end else if (bus.eret_req) begin
            r_eret  <= 1'b1;
            r_stall <= 1'b1;
            r_state <= ST_RET;
          end else if (w_irq_take) begin
            r_cause <= 5'd0;
            r_exc   <= 1'b1;
            r_stall <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.cp0_ans) begin
            r_cnt   <= LP_FLUSH;
            r_flush <= 1'b1;
            r_state <= ST_FLUSH;
          end else begin
            // CP0 refused the entry: release the pipeline without a flush.
            r_stall <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RET: begin
          r_cnt   <= LP_FLUSH;
          r_flush <= 1'b1;
          r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_flush <= 1'b0;
            r_stall <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_flush <= 1'b0;
          r_stall <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cp0_exception = r_exc;
  assign bus.cp0_eret      = r_eret;
  assign bus.cp0_cause     = r_cause;
  assign bus.stall         = r_stall;
  assign bus.flush         = r_flush;
  assign bus.irq_pending   = r_pending;

endmodule

// File: tb/tb_exc_sequencer.sv
// Cycle-table and scoreboard bench for exc_sequencer (FLUSH_CYCLES=2 and 3 instances).
module tb_exc_sequencer;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  typedef struct packed {
    logic       exc;
    logic       eret;
    logic [4:0] cause;
    logic       stall;
    logic       flush;
    logic [5:0] pend;
  } out_t;

  typedef struct packed {
    logic       sync;
    logic [4:0] code;
    logic       eret;
    logic [5:0] irq;
    logic [5:0] mask;
    logic [5:0] clr;
    logic       ie;
    logic       ans;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  out_t exp_q[$];
  vec_t tbl[36];

  always #5 clk = ~clk;

  exc_sequencer_if #(.N_IRQ(6)) ifa ();
  exc_sequencer_if #(.N_IRQ(6)) ifb ();

  exc_sequencer #(.N_IRQ(6), .FLUSH_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  exc_sequencer #(.N_IRQ(6), .FLUSH_CYCLES(3)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  function automatic vec_t mk(logic s, logic [4:0] c, logic e, logic [5:0] irq,
                              logic [5:0] m, logic [5:0] clr, logic ie, logic ans,
                              logic xe, logic xr, logic [4:0] xc, logic xs,
                              logic xf, logic [5:0] xp);
    vec_t v;
    v.sync = s; v.code = c; v.eret = e; v.irq = irq; v.mask = m; v.clr = clr;
    v.ie = ie; v.ans = ans;
    v.exp.exc = xe; v.exp.eret = xr; v.exp.cause = xc; v.exp.stall = xs;
    v.exp.flush = xf; v.exp.pend = xp;
    return v;
  endfunction

  function automatic out_t get_a();
    out_t o;
    o.exc = ifa.cp0_exception; o.eret = ifa.cp0_eret; o.cause = ifa.cp0_cause;
    o.stall = ifa.stall; o.flush = ifa.flush; o.pend = ifa.irq_pending;
    return o;
  endfunction

  function automatic out_t get_b();
    out_t o;
    o.exc = ifb.cp0_exception; o.eret = ifb.cp0_eret; o.cause = ifb.cp0_cause;
    o.stall = ifb.stall; o.flush = ifb.flush; o.pend = ifb.irq_pending;
    return o;
  endfunction

  task automatic chk(input string name, input out_t act);
    out_t req;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, act exc=%b eret=%b cause=%0d stall=%b flush=%b pend=%h",
               name, act.exc, act.eret, act.cause, act.stall, act.flush, act.pend);
      return;
    end
    req = exp_q.pop_front();
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("%s ok: exc=%b eret=%b cause=%0d stall=%b flush=%b pend=%h",
               name, act.exc, act.eret, act.cause, act.stall, act.flush, act.pend);
    end else begin
      $display("FAIL %s: act exc=%b eret=%b cause=%0d stall=%b flush=%b pend=%h, req exc=%b eret=%b cause=%0d stall=%b flush=%b pend=%h",
               name, act.exc, act.eret, act.cause, act.stall, act.flush, act.pend,
               req.exc, req.eret, req.cause, req.stall, req.flush, req.pend);
    end
  endtask

  task automatic apply_a(input vec_t v, input int idx);
    ifa.sync_exc_valid = v.sync; ifa.sync_exc_code = v.code; ifa.eret_req = v.eret;
    ifa.irq = v.irq; ifa.irq_mask = v.mask; ifa.irq_clr = v.clr;
    ifa.ie = v.ie; ifa.cp0_ans = v.ans;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    chk($sformatf("a_row%0d", idx), get_a());
  endtask

  task automatic step_b(input logic eret, input logic xr, input logic xs,
                        input logic xf, input string name);
    out_t e;
    ifb.eret_req = eret;
    e = '0;
    e.eret = xr; e.stall = xs; e.flush = xf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk(name, get_b());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.sync_exc_valid = O; ifa.sync_exc_code = 5'd0; ifa.eret_req = O;
    ifa.irq = 6'h01; ifa.irq_mask = 6'h00; ifa.irq_clr = 6'h00;
    ifa.ie = O; ifa.cp0_ans = O;
    ifb.sync_exc_valid = O; ifb.sync_exc_code = 5'd0; ifb.eret_req = O;
    ifb.irq = 6'h00; ifb.irq_mask = 6'h00; ifb.irq_clr = 6'h00;
    ifb.ie = O; ifb.cp0_ans = O;

    // cols: sync code eret irq mask clr ie ans | exc eret cause stall flush pend
    tbl[0]  = mk(O,5'd0, O,6'h01,6'h00,6'h00,O,O, O,O,5'd0, O,O,6'h01);
    tbl[1]  = mk(O,5'd0, O,6'h01,6'h00,6'h00,O,O, O,O,5'd0, O,O,6'h01);
    tbl[2]  = mk(O,5'd0, O,6'h01,6'h00,6'h01,O,O, O,O,5'd0, O,O,6'h00);
    tbl[3]  = mk(I,5'd8, O,6'h01,6'h00,6'h00,O,O, I,O,5'd8, I,O,6'h00);
    tbl[4]  = mk(O,5'd0, O,6'h01,6'h00,6'h00,O,I, O,O,5'd8, I,O,6'h00);
    tbl[5]  = mk(O,5'd0, O,6'h01,6'h00,6'h00,O,I, O,O,5'd8, I,I,6'h00);
    tbl[6]  = mk(O,5'd0, O,6'h01,6'h00,6'h00,O,O, O,O,5'd8, I,I,6'h00);
    tbl[7]  = mk(O,5'd0, O,6'h01,6'h00,6'h00,O,O, O,O,5'd8, O,O,6'h00);
    tbl[8]  = mk(O,5'd0, O,6'h00,6'h04,6'h00,I,O, O,O,5'd8, O,O,6'h00);
    tbl[9]  = mk(O,5'd0, O,6'h04,6'h04,6'h00,I,O, O,O,5'd8, O,O,6'h04);
    tbl[10] = mk(O,5'd0, O,6'h04,6'h04,6'h00,I,I, I,O,5'd0, I,O,6'h04);
    tbl[11] = mk(O,5'd0, O,6'h04,6'h04,6'h00,O,I, O,O,5'd0, I,O,6'h04);
    tbl[12] = mk(O,5'd0, O,6'h04,6'h04,6'h00,O,I, O,O,5'd0, I,I,6'h04);
    tbl[13] = mk(O,5'd0, O,6'h04,6'h04,6'h00,O,O, O,O,5'd0, I,I,6'h04);
    tbl[14] = mk(O,5'd0, O,6'h04,6'h04,6'h04,O,O, O,O,5'd0, O,O,6'h00);
    tbl[15] = mk(O,5'd0, O,6'h00,6'h00,6'h00,I,O, O,O,5'd0, O,O,6'h00);
    tbl[16] = mk(O,5'd0, O,6'h04,6'h00,6'h00,I,O, O,O,5'd0, O,O,6'h04);
    tbl[17] = mk(O,5'd0, O,6'h04,6'h00,6'h00,I,O, O,O,5'd0, O,O,6'h04);
    tbl[18] = mk(O,5'd0, O,6'h04,6'h00,6'h00,I,O, O,O,5'd0, O,O,6'h04);
    tbl[19] = mk(I,5'd13,I,6'h04,6'h04,6'h00,I,O, I,O,5'd13,I,O,6'h04);
    tbl[20] = mk(O,5'd0, O,6'h04,6'h04,6'h00,I,O, O,O,5'd13,I,O,6'h04);
    tbl[21] = mk(O,5'd0, O,6'h04,6'h04,6'h00,O,O, O,O,5'd13,O,O,6'h04);
    tbl[22] = mk(O,5'd0, O,6'h04,6'h04,6'h00,O,O, O,O,5'd13,O,O,6'h04);
    tbl[23] = mk(O,5'd0, I,6'h04,6'h00,6'h04,O,O, O,I,5'd13,I,O,6'h00);
    tbl[24] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,O, O,O,5'd13,I,I,6'h00);
    tbl[25] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,O, O,O,5'd13,I,I,6'h00);
    tbl[26] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,O, O,O,5'd13,O,O,6'h00);
    tbl[27] = mk(I,5'd9, O,6'h04,6'h00,6'h00,O,O, I,O,5'd9, I,O,6'h00);
    tbl[28] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,I, O,O,5'd9, I,O,6'h00);
    tbl[29] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,I, O,O,5'd9, I,I,6'h00);
    tbl[30] = mk(O,5'd0, I,6'h04,6'h00,6'h00,O,O, O,O,5'd9, I,I,6'h00);
    tbl[31] = mk(O,5'd0, I,6'h04,6'h00,6'h00,O,O, O,O,5'd9, O,O,6'h00);
    tbl[32] = mk(O,5'd0, I,6'h04,6'h00,6'h00,O,O, O,I,5'd9, I,O,6'h00);
    tbl[33] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,O, O,O,5'd9, I,I,6'h00);
    tbl[34] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,O, O,O,5'd9, I,I,6'h00);
    tbl[35] = mk(O,5'd0, O,6'h04,6'h00,6'h00,O,O, O,O,5'd9, O,O,6'h00);

    // Held in reset with a line high: everything stays zero across clock edges.
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    chk("a_reset_hold", get_a());
    exp_q.push_back('0);
    chk("b_reset_hold", get_b());
    #3;
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < 36; i++) begin
      apply_a(tbl[i], i);
    end

    // FLUSH_CYCLES=3: full eret, then an eret cut short by reset in its second flush cycle.
    step_b(I, I, I, O, "b_eret");
    step_b(O, O, I, I, "b_flush1");
    step_b(O, O, I, I, "b_flush2");
    step_b(O, O, I, I, "b_flush3");
    step_b(O, O, O, O, "b_idle");
    step_b(I, I, I, O, "b_eret2");
    step_b(O, O, I, I, "b_flush1_2");
    step_b(O, O, I, I, "b_flush2_2");
    rst_b = 1'b0;
    #1;
    exp_q.push_back('0);
    chk("b_reset_async", get_b());
    @(posedge clk);
    #3;
    rst_b = 1'b1;
    step_b(O, O, O, O, "b_after_rel1");
    step_b(O, O, O, O, "b_after_rel2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt sequencer in front of the CP0 coprocessor. It arbitrates synchronous exceptions from decode, `eret` requests and latched external interrupts, then drives CP0's `exception`/`cause`/`eret` inputs one request at a time. It holds the pipeline while a request is in flight and issues a timed pipeline flush after every accepted entry or return.

## Interface
- `N_IRQ`, default 6: number of external interrupt lines (1..8).
- `FLUSH_CYCLES`, default 2: length of the flush window in cycles (1..15).

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `sync_exc_valid`  in  1  one-cycle pulse from decode: synchronous exception (syscall/break/teq).
- `sync_exc_code`  in  5  cause code accompanying `sync_exc_valid`.
- `eret_req`  in  1  one-cycle pulse from decode: `eret` instruction.
- `irq`  in  N_IRQ  external interrupt lines, already synchronous to `clk`.
- `irq_mask`  in  N_IRQ  per-line enable, 1 = enabled.
- `irq_clr`  in  N_IRQ  write-one-to-clear pulse per pending bit (software ack).
- `ie`  in  1  global interrupt enable (CP0 status bit 0).
- `cp0_ans`  in  1  CP0 `ans_exception`; 1 = entry accepted.
- `cp0_exception`  out  1  exception strobe to CP0.
- `cp0_eret`  out  1  eret strobe to CP0.
- `cp0_cause`  out  5  cause code to CP0.
- `stall`  out  1  pipeline hold.
- `flush`  out  1  pipeline flush.
- `irq_pending`  out  N_IRQ  sticky pending bits.

## Operation
- **Pending latch:** `irq_q` registers `irq`. Pending bit i is set on a rising edge of line i (`irq[i] & ~irq_q[i]`) and cleared by `irq_clr[i]`. Set wins over clear in the same cycle. Pending bits update in every state.
- **FSM states:** IDLE, REQ, WAIT, RET, FLUSH.
- **IDLE:** requests are sampled only here. Priority order:
  - `sync_exc_valid`: latch `sync_exc_code` into the cause register, go to REQ.
  - else `eret_req`: go to RET.
  - else `ie & |(irq_pending & irq_mask)`: cause register = 5'd0, go to REQ.
  - else stay in IDLE.
  - If `sync_exc_valid` and `eret_req` arrive together, `eret_req` is dropped.
- **REQ:** `cp0_exception` = 1 for exactly one cycle; `cp0_cause` = cause register. Next state is WAIT.
- **WAIT:** sample `cp0_ans`.
  - 1: load the counter with FLUSH_CYCLES, go to FLUSH.
  - 0 (CP0 has exceptions disabled): go to IDLE with no flush. Pending bits are untouched.
- **RET:** `cp0_eret` = 1 for one cycle. Load the counter with FLUSH_CYCLES, go to FLUSH.
- **FLUSH:** `flush` = 1. Counter decrements each cycle; when the counter reads 1, go to IDLE.
- **Outputs:**
  - `stall` = (state != IDLE).
  - `cp0_cause` holds the cause register at all times; it is 0 outside REQ unless latched.
  - All outputs decode from registered state (Moore); there are no combinational input-to-output paths.
  - Requests arriving outside IDLE are ignored; decode is stalled and does not issue them.
- **Taken interrupts:** a taken interrupt does not clear its pending bit; software clears it via `irq_clr`. Re-entry is prevented because CP0 clears `ie` on entry.
- **Counter:** 4 bits, unsigned, never wraps below 1 in FLUSH.

## Timing
- **Reset values** (async assert, sync release): state IDLE, counter 0, cause 0, `irq_q` 0, `irq_pending` 0. `cp0_exception`, `cp0_eret`, `stall`, `flush` all 0.
- **Reset mid-operation:** all strobes drop immediately; nothing is replayed after release.
- **Rising edge after reset:** `irq_q` resets to 0, so a line already high at release sets its pending bit on the first clock edge.
- **Exception path:** request sampled at edge E0 →
  - `cp0_exception` high in cycle E0..E1
  - WAIT during E1..E2, with `cp0_ans` valid
  - `flush` high from E2 for FLUSH_CYCLES cycles
  - IDLE, `stall` low, at E2+FLUSH_CYCLES
- **Total stall:** 2+FLUSH_CYCLES cycles if accepted, 2 if rejected.
- **Eret path:** `cp0_eret` high E0..E1; `flush` high from E1 for FLUSH_CYCLES cycles; total stall 1+FLUSH_CYCLES.
- **Back-to-back:** a request present in the first IDLE cycle after FLUSH is accepted; there are no dead cycles.

## Test plan
- **Reset:** hold reset low with `irq`=6'h01 → all outputs 0. After release, `irq_pending`=6'h01 after the first edge, and no entry occurs while `ie`=0.
- **Syscall:** `sync_exc_valid`=1, code=8, `cp0_ans`=1 in WAIT → `cp0_exception` high 1 cycle with `cp0_cause`=8; `flush` high 2 cycles; `stall` high 4 cycles.
- **Interrupt:** `ie`=1, `irq_mask`=6'h04, rising edge on `irq[2]` → REQ with cause 0. After `irq_clr`=6'h04, pending=0. Repeat with `irq_mask`=0 → no entry.
- **Simultaneous requests:** `sync_exc_valid`, `eret_req` and a pending masked-in interrupt in the same cycle → only the exception is issued; `cp0_eret` never asserts.
- **Rejected entry:** `cp0_ans`=0 in WAIT → return to IDLE after 2 stall cycles with no `flush`, and `irq_pending` unchanged.
- **Eret with FLUSH_CYCLES=3:** `cp0_eret` high 1 cycle, `flush` high 3 cycles. Assert reset during the second flush cycle → `flush`/`stall` drop immediately, and state is IDLE after release.
